// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register count of in-flight register-file writers.
// Drives the ID-stage RAW stall and the forward-data hints for the operand muxes.
module rf_scoreboard #(
   parameter int unsigned NREG  = 32,
   parameter int unsigned CNT_W = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       flush,
   input  logic       issue_valid,
   input  logic       issue_we,
   input  logic [4:0] issue_waddr,
   input  logic       issue_late,
   input  logic       ready_valid,
   input  logic [4:0] ready_waddr,
   input  logic       retire_valid,
   input  logic [4:0] retire_waddr,
   input  logic [4:0] rf_raddr1,
   input  logic [4:0] rf_raddr2,
   input  logic [4:0] id_waddr,
   input  logic       id_we,
   output logic       stall,
   output logic       src1_pending,
   output logic       src2_pending,
   output logic       err
);

   localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

   logic [CNT_W-1:0] wcnt_q [NREG];
   logic [CNT_W-1:0] wcnt_d [NREG];
   logic [CNT_W-1:0] lcnt_q [NREG];
   logic [CNT_W-1:0] lcnt_d [NREG];
   logic             err_q, err_d;

   // Next state: apply the net per-register change; an illegal change is dropped and flagged.
   always_comb begin
      logic             inc_w, inc_l, dec_w, dec_l;
      logic             w_up, w_dn, l_up, l_dn, bad;
      logic [CNT_W-1:0] w_nx, l_nx;
      err_d = err_q;
      inc_w = 1'b0;
      inc_l = 1'b0;
      dec_w = 1'b0;
      dec_l = 1'b0;
      w_up  = 1'b0;
      w_dn  = 1'b0;
      l_up  = 1'b0;
      l_dn  = 1'b0;
      bad   = 1'b0;
      w_nx  = '0;
      l_nx  = '0;
      for (int i = 0; i < NREG; i++) begin
         wcnt_d[i] = wcnt_q[i];
         lcnt_d[i] = lcnt_q[i];
      end
      if (flush) begin
         // Flush squashes everything; same-cycle events are discarded silently.
         for (int i = 0; i < NREG; i++) begin
            wcnt_d[i] = '0;
            lcnt_d[i] = '0;
         end
      end else begin
         for (int i = 1; i < NREG; i++) begin
            inc_w = issue_valid & issue_we & (issue_waddr == 5'(i));
            inc_l = inc_w & issue_late;
            dec_l = ready_valid & (ready_waddr == 5'(i));
            dec_w = retire_valid & (retire_waddr == 5'(i));
            // Same-register increment and decrement cancel out.
            w_up  = inc_w & ~dec_w;
            w_dn  = dec_w & ~inc_w;
            l_up  = inc_l & ~dec_l;
            l_dn  = dec_l & ~inc_l;
            w_nx  = wcnt_q[i] + CNT_W'(w_up) - CNT_W'(w_dn);
            l_nx  = lcnt_q[i] + CNT_W'(l_up) - CNT_W'(l_dn);
            bad   = (w_up & (wcnt_q[i] == CntMax)) | (w_dn & (wcnt_q[i] == '0)) |
                    (l_up & (lcnt_q[i] == CntMax)) | (l_dn & (lcnt_q[i] == '0));
            if (!bad && (l_nx > w_nx)) begin
               bad = 1'b1;
            end
            if (bad) begin
               err_d = 1'b1;
            end else begin
               wcnt_d[i] = w_nx;
               lcnt_d[i] = l_nx;
            end
         end
      end
      wcnt_d[0] = '0;
      lcnt_d[0] = '0;
   end

   // State register with synchronous reset; reset overrides flush.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) begin
            wcnt_q[i] <= '0;
            lcnt_q[i] <= '0;
         end
         err_q <= 1'b0;
      end else begin
         for (int i = 0; i < NREG; i++) begin
            wcnt_q[i] <= wcnt_d[i];
            lcnt_q[i] <= lcnt_d[i];
         end
         err_q <= err_d;
      end
   end

   // Outputs look only at registered state plus the current ID addresses.
   always_comb begin
      src1_pending = (rf_raddr1 != '0) & (wcnt_q[rf_raddr1] != '0);
      src2_pending = (rf_raddr2 != '0) & (wcnt_q[rf_raddr2] != '0);
      stall        = ((rf_raddr1 != '0) & (lcnt_q[rf_raddr1] != '0)) |
                     ((rf_raddr2 != '0) & (lcnt_q[rf_raddr2] != '0)) |
                     (id_we & (id_waddr != '0) & (wcnt_q[id_waddr] == CntMax));
      err          = err_q;
   end

endmodule

// File: tb/tb_rf_scoreboard.sv
// tb_rf_scoreboard: directed scenarios plus randomized traffic against a counting model.
module tb_rf_scoreboard;

   logic       clk = 1'b0;
   logic       reset, flush;
   logic       issue_valid, issue_we, issue_late, ready_valid, retire_valid, id_we;
   logic [4:0] issue_waddr, ready_waddr, retire_waddr, rf_raddr1, rf_raddr2, id_waddr;
   logic       stall, src1_pending, src2_pending, err;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: plain integer counts of outstanding and late writers per register.
   int mw [32];
   int ml [32];
   bit merr;

   rf_scoreboard #(.NREG(32), .CNT_W(2)) dut (
      .clk          (clk),
      .reset        (reset),
      .flush        (flush),
      .issue_valid  (issue_valid),
      .issue_we     (issue_we),
      .issue_waddr  (issue_waddr),
      .issue_late   (issue_late),
      .ready_valid  (ready_valid),
      .ready_waddr  (ready_waddr),
      .retire_valid (retire_valid),
      .retire_waddr (retire_waddr),
      .rf_raddr1    (rf_raddr1),
      .rf_raddr2    (rf_raddr2),
      .id_waddr     (id_waddr),
      .id_we        (id_we),
      .stall        (stall),
      .src1_pending (src1_pending),
      .src2_pending (src2_pending),
      .err          (err)
   );

   always #5 clk = ~clk;

   task automatic model_update();
      int dw [32];
      int dl [32];
      int nw, nl;
      if (reset) begin
         for (int i = 0; i < 32; i++) begin mw[i] = 0; ml[i] = 0; end
         merr = 1'b0;
      end else if (flush) begin
         for (int i = 0; i < 32; i++) begin mw[i] = 0; ml[i] = 0; end
      end else begin
         for (int i = 0; i < 32; i++) begin dw[i] = 0; dl[i] = 0; end
         if (issue_valid && issue_we) begin
            dw[issue_waddr]++;
            if (issue_late) dl[issue_waddr]++;
         end
         if (ready_valid) dl[ready_waddr]--;
         if (retire_valid) dw[retire_waddr]--;
         for (int i = 1; i < 32; i++) begin
            nw = mw[i] + dw[i];
            nl = ml[i] + dl[i];
            if (nw < 0 || nw > 3 || nl < 0 || nl > 3 || nl > nw) merr = 1'b1;
            else begin mw[i] = nw; ml[i] = nl; end
         end
      end
   endtask

   function automatic bit exp_stall();
      return (rf_raddr1 != 0 && ml[rf_raddr1] != 0) || (rf_raddr2 != 0 && ml[rf_raddr2] != 0) ||
             (id_we && id_waddr != 0 && mw[id_waddr] == 3);
   endfunction

   function automatic bit exp_src(input logic [4:0] a);
      return a != 0 && mw[a] != 0;
   endfunction

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic clr();
      flush = 0; issue_valid = 0; issue_we = 0; issue_late = 0; issue_waddr = 0;
      ready_valid = 0; ready_waddr = 0; retire_valid = 0; retire_waddr = 0;
      id_we = 0; id_waddr = 0;
   endtask

   task automatic test_reset();
      clr(); rf_raddr1 = 5; rf_raddr2 = 0;
      retire_valid = 1; retire_waddr = 3;   // retire with nothing outstanding
      tick(); clr(); #1;
      n_assert++;
      if (err !== 1'b1) begin n_fail++; $display("FAIL reset_pre_err: got %b want 1", err); end
      issue_valid = 1; issue_we = 1; issue_late = 1; issue_waddr = 5;
      tick();
      reset = 1; flush = 1;                 // reset and flush together, plus an issue
      tick(); reset = 0; clr(); id_we = 1; id_waddr = 5; #1;
      n_assert += 4;
      if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall); end
      if (src1_pending !== 1'b0) begin n_fail++; $display("FAIL reset_src1: got %b want 0", src1_pending); end
      if (src2_pending !== 1'b0) begin n_fail++; $display("FAIL reset_src2: got %b want 0", src2_pending); end
      if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
   endtask

   task automatic test_early_writer();
      clr(); rf_raddr1 = 5; rf_raddr2 = 0;
      issue_valid = 1; issue_we = 1; issue_waddr = 5;
      tick(); clr(); #1;
      n_assert += 2;
      if (src1_pending !== 1'b1) begin n_fail++; $display("FAIL early_src1: got %b want 1", src1_pending); end
      if (stall !== 1'b0) begin n_fail++; $display("FAIL early_stall: got %b want 0", stall); end
      tick(); tick();
      retire_valid = 1; retire_waddr = 5; #1;
      n_assert++;
      if (src1_pending !== 1'b1) begin n_fail++; $display("FAIL early_src1_retire_cycle: got %b want 1", src1_pending); end
      tick(); clr(); #1;
      n_assert++;
      if (src1_pending !== 1'b0) begin n_fail++; $display("FAIL early_src1_after: got %b want 0", src1_pending); end
   endtask

   task automatic test_late_writer();
      clr(); rf_raddr1 = 0; rf_raddr2 = 7;
      issue_valid = 1; issue_we = 1; issue_late = 1; issue_waddr = 7;
      #1;
      n_assert++;
      if (stall !== 1'b0) begin n_fail++; $display("FAIL late_no_bypass: got %b want 0", stall); end
      tick(); clr(); #1;
      n_assert += 2;
      if (stall !== 1'b1) begin n_fail++; $display("FAIL late_stall: got %b want 1", stall); end
      if (src2_pending !== 1'b1) begin n_fail++; $display("FAIL late_src2: got %b want 1", src2_pending); end
      ready_valid = 1; ready_waddr = 7;
      tick(); clr(); #1;
      n_assert += 2;
      if (stall !== 1'b0) begin n_fail++; $display("FAIL late_ready_stall: got %b want 0", stall); end
      if (src2_pending !== 1'b1) begin n_fail++; $display("FAIL late_ready_src2: got %b want 1", src2_pending); end
      retire_valid = 1; retire_waddr = 7;
      tick(); clr(); #1;
      n_assert += 2;
      if (src2_pending !== 1'b0) begin n_fail++; $display("FAIL late_retire_src2: got %b want 0", src2_pending); end
      if (err !== 1'b0) begin n_fail++; $display("FAIL late_err: got %b want 0", err); end
   endtask

   task automatic test_saturation();
      clr(); rf_raddr1 = 9; rf_raddr2 = 0;
      issue_valid = 1; issue_we = 1; issue_waddr = 9;
      tick(); tick(); tick();
      clr(); id_we = 1; id_waddr = 9; #1;
      n_assert += 2;
      if (stall !== 1'b1) begin n_fail++; $display("FAIL sat_stall: got %b want 1", stall); end
      if (err !== 1'b0) begin n_fail++; $display("FAIL sat_err_pre: got %b want 0", err); end
      issue_valid = 1; issue_we = 1; issue_waddr = 9;
      tick(); clr(); id_we = 1; id_waddr = 9; #1;
      n_assert += 2;
      if (err !== 1'b1) begin n_fail++; $display("FAIL sat_err: got %b want 1", err); end
      if (stall !== 1'b1) begin n_fail++; $display("FAIL sat_held: got %b want 1", stall); end
      id_we = 0;
      for (int k = 0; k < 3; k++) begin
         retire_valid = 1; retire_waddr = 9;
         tick(); clr(); #1;
         n_assert++;
         if (src1_pending !== (k != 2)) begin
            n_fail++;
            $display("FAIL sat_drain_%0d: got %b want %b", k, src1_pending, k != 2);
         end
      end
      reset = 1; tick(); reset = 0;
   endtask

   task automatic test_flush();
      clr(); rf_raddr1 = 4; rf_raddr2 = 4;
      issue_valid = 1; issue_we = 1; issue_late = 1; issue_waddr = 4;
      tick(); clr(); #1;
      n_assert++;
      if (stall !== 1'b1) begin n_fail++; $display("FAIL flush_pre_stall: got %b want 1", stall); end
      flush = 1; issue_valid = 1; issue_we = 1; issue_late = 1; issue_waddr = 4;
      ready_valid = 1; ready_waddr = 20;   // would be illegal without the flush
      tick(); clr(); #1;
      n_assert += 3;
      if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall: got %b want 0", stall); end
      if (src1_pending !== 1'b0) begin n_fail++; $display("FAIL flush_src1: got %b want 0", src1_pending); end
      if (err !== 1'b0) begin n_fail++; $display("FAIL flush_err: got %b want 0", err); end
   endtask

   task automatic test_same_cycle_and_r0();
      clr(); rf_raddr1 = 12; rf_raddr2 = 0;
      issue_valid = 1; issue_we = 1; issue_waddr = 12;
      tick();
      retire_valid = 1; retire_waddr = 12;
      tick(); clr(); #1;
      n_assert++;
      if (src1_pending !== 1'b1) begin n_fail++; $display("FAIL same_cycle_src1: got %b want 1", src1_pending); end
      retire_valid = 1; retire_waddr = 12;
      tick(); clr(); #1;
      n_assert += 2;
      if (src1_pending !== 1'b0) begin n_fail++; $display("FAIL same_cycle_drain: got %b want 0", src1_pending); end
      if (err !== 1'b0) begin n_fail++; $display("FAIL same_cycle_err: got %b want 0", err); end
      rf_raddr1 = 0; rf_raddr2 = 0;
      for (int k = 0; k < 4; k++) begin
         issue_valid = 1; issue_we = 1; issue_late = 1; issue_waddr = 0;
         ready_valid = 1; ready_waddr = 0; retire_valid = 1; retire_waddr = 0;
         tick();
      end
      clr(); id_we = 1; id_waddr = 0; #1;
      n_assert += 4;
      if (stall !== 1'b0) begin n_fail++; $display("FAIL r0_stall: got %b want 0", stall); end
      if (src1_pending !== 1'b0) begin n_fail++; $display("FAIL r0_src1: got %b want 0", src1_pending); end
      if (src2_pending !== 1'b0) begin n_fail++; $display("FAIL r0_src2: got %b want 0", src2_pending); end
      if (err !== 1'b0) begin n_fail++; $display("FAIL r0_err: got %b want 0", err); end
   endtask

   function automatic logic [4:0] pick_reg();
      logic [4:0] r;
      if ($urandom_range(3, 0) == 0) r = 5'($urandom_range(31, 0));
      else r = 5'($urandom_range(7, 0));
      return r;
   endfunction

   task automatic test_random();
      bit wild;
      clr(); reset = 1; tick(); reset = 0;
      for (int c = 0; c < 3000; c++) begin
         wild = (c >= 2500) && ($urandom_range(39, 0) == 0);
         flush = ($urandom_range(47, 0) == 0);
         issue_valid = 1'($urandom_range(1, 0));
         issue_we = ($urandom_range(3, 0) != 0);
         issue_late = 1'($urandom_range(1, 0));
         issue_waddr = pick_reg();
         if (!wild && mw[issue_waddr] >= 3) issue_valid = 0;
         ready_waddr = pick_reg();
         ready_valid = 1'($urandom_range(1, 0)) && (wild || ml[ready_waddr] > 0);
         retire_waddr = pick_reg();
         retire_valid = 1'($urandom_range(1, 0)) && (wild || mw[retire_waddr] > ml[retire_waddr]);
         rf_raddr1 = pick_reg();
         rf_raddr2 = pick_reg();
         id_waddr = pick_reg();
         id_we = 1'($urandom_range(1, 0));
         #1;
         n_assert += 4;
         if (stall !== exp_stall()) begin
            n_fail++; $display("FAIL rand_stall cyc %0d: got %b want %b", c, stall, exp_stall());
         end
         if (src1_pending !== exp_src(rf_raddr1)) begin
            n_fail++;
            $display("FAIL rand_src1 cyc %0d: got %b want %b", c, src1_pending, exp_src(rf_raddr1));
         end
         if (src2_pending !== exp_src(rf_raddr2)) begin
            n_fail++;
            $display("FAIL rand_src2 cyc %0d: got %b want %b", c, src2_pending, exp_src(rf_raddr2));
         end
         if (err !== merr) begin
            n_fail++; $display("FAIL rand_err cyc %0d: got %b want %b", c, err, merr);
         end
         tick();
      end
   endtask

   initial begin
      clr(); reset = 1; rf_raddr1 = 0; rf_raddr2 = 0;
      tick(); tick();
      reset = 0;
      test_reset();
      test_early_writer();
      test_late_writer();
      test_saturation();
      test_flush();
      test_same_cycle_and_r0();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/rf_scoreboard.md
Name: rf_scoreboard

Overview:
- Per-register scoreboard for the 5-stage pipeline register file; decides when ID must stall on a RAW hazard.
- Tracks every in-flight write issued from ID to EX. Flags writers whose result is late: load, CSR read, or multiply, i.e. not forwardable until their ready event.
- ID raises stall while a source register has an outstanding late writer, or while a destination counter is saturated.
- Forwarding-needed hints go to the ID operand muxes.

Parameters:
- NREG, 32, number of architectural registers; r0 is never tracked.
- CNT_W, 2, width of each per-register counter; max outstanding writers per register = 2^CNT_W-1 = 3.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- flush  input  1  exception/ertn flush; squashes all in-flight writers
- issue_valid  input  1  instruction leaves ID for EX this cycle
- issue_we  input  1  issuing instruction writes rf
- issue_waddr  input  5  destination register of issuing instruction
- issue_late  input  1  issuing writer's result is late (load/CSR/mul)
- ready_valid  input  1  a late writer's result became forwardable this cycle
- ready_waddr  input  5  destination of that late writer
- retire_valid  input  1  WB writes rf this cycle
- retire_waddr  input  5  destination written by WB
- rf_raddr1  input  5  ID source 1
- rf_raddr2  input  5  ID source 2
- id_waddr  input  5  destination of instruction currently in ID
- id_we  input  1  instruction in ID writes rf
- stall  output  1  ID must not issue this cycle
- src1_pending  output  1  rf_raddr1 has an outstanding writer (use forward data)
- src2_pending  output  1  rf_raddr2 has an outstanding writer
- err  output  1  sticky protocol error

Behaviour:
- State per register i in 1..31:
  - wcnt[i]: outstanding writers, CNT_W bits.
  - lcnt[i]: outstanding late writers not yet ready, CNT_W bits.
- Register 0 state is constantly 0; all events addressing r0 are ignored.
- Reset (synchronous): all wcnt/lcnt = 0, err = 0. Outputs after reset: stall = 0, src1_pending = 0, src2_pending = 0, err = 0.
- Qualifying events:
  - inc_w = issue_valid & issue_we & ~flush.
  - inc_l = inc_w & issue_late.
  - dec_l = ready_valid.
  - dec_w = retire_valid.
- Per-register update at the clock edge: wcnt += inc_w(i) - dec_w(i); lcnt += inc_l(i) - dec_l(i).
  - Same register, same cycle, increment and decrement: net unchanged.
  - Events on different registers are independent.
- Flush has priority over all events: next state is all wcnt = lcnt = 0. A same-cycle issue is dropped. Same-cycle retire/ready are discarded without error.
- Latency: an issue in cycle t is visible to stall/pending from cycle t+1. Outputs are combinational from the current state plus the ID address inputs; there is no same-cycle bypass of incoming events.
- src_n_pending = (rf_raddrN != 0) & (wcnt[rf_raddrN] != 0).
- stall is asserted on any of:
  - (rf_raddr1 != 0) & (lcnt[rf_raddr1] != 0)
  - (rf_raddr2 != 0) & (lcnt[rf_raddr2] != 0)
  - id_we & (id_waddr != 0) & (wcnt[id_waddr] == max)
- Stall is conservative: a younger early writer does not hide an older late writer.
- err sets, and stays set until reset, on any of the following (the offending update is ignored, counter held):
  - wcnt or lcnt increment at max.
  - wcnt or lcnt decrement at 0.
  - lcnt would exceed wcnt.
- flush together with reset: reset wins; identical end state.

Test Plan:
- Reset, then rf_raddr1 = 5 with no issues → stall = 0, src1_pending = 0, err = 0.
- Issue early writer r5 at t; r5 read at t+1 → src1_pending = 1, stall = 0. Retire r5 at t+3 → src1_pending = 0 from t+4.
- Issue late writer r7 (load) at t; read r7 → stall = 1 from t+1. ready r7 at t+2 → stall = 0 at t+3, src_pending still 1 until retire.
- Three issues to r9 with no retire → wcnt = 3. ID has id_we = 1, id_waddr = 9 → stall = 1. Issue of a 4th anyway → err = 1, wcnt stays 3.
- Load to r4 in flight with lcnt = 1; flush asserted with simultaneous issue to r4 → next cycle all pending = 0, stall = 0, err = 0.
- Same-cycle issue and retire on r12 with wcnt = 1 → wcnt remains 1. Issue/ready/retire addressing r0 → no state change, no stall.
